commit_trace_monitor: RTL

- Parametrised per-commit trace recorder for the pipelined CPU verification environment; sits beside the cpu top and taps writeback/memory-stage commit signals.
- Classifies each committed instruction (load, reg-write, store, nop/branch, halt), numbers it, counts cycles and instructions, and buffers trace records in a FIFO drained over a valid/ready handshake.
- Adds a watchdog timeout and overflow detection to the flat per-cycle log used so far.

---
 rtl/commit_trace_pkg.sv | 40 ++++
 rtl/commit_trace_monitor_if.sv | 74 +++++++
 rtl/commit_trace_monitor_trace_fifo.sv | 55 +++++
 rtl/commit_trace_monitor.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/commit_trace_pkg.sv
// Shared types for the commit trace monitor: record kinds, the trace record layout
// and the commit classification rule.
package commit_trace_pkg;

   localparam int PKG_DATA_W     = 16;
   localparam int PKG_REG_ADDR_W = 4;
   localparam int PKG_CNT_W      = 32;

   typedef enum logic [2:0] {
      KIND_NOP  = 3'd0,
      KIND_REG  = 3'd1,
      KIND_LD   = 3'd2,
      KIND_ST   = 3'd3,
      KIND_HALT = 3'd4
   } trace_kind_e;

   typedef struct packed {
      trace_kind_e                kind;
      logic [PKG_CNT_W-1:0]       inst_num;
      logic [PKG_DATA_W-1:0]      pc;
      logic [PKG_REG_ADDR_W-1:0]  reg_idx;
      logic [PKG_DATA_W-1:0]      value;
      logic [PKG_DATA_W-1:0]      addr;
   } trace_rec_t;

   // A load also writes a register, so it must be tested before plain reg-write.
   function automatic trace_kind_e classify_commit(
      input logic reg_write,
      input logic mem_read,
      input logic mem_write,
      input logic halt
   );
      if (reg_write && mem_read) return KIND_LD;
      if (reg_write)             return KIND_REG;
      if (halt)                  return KIND_HALT;
      if (mem_write)             return KIND_ST;
      return KIND_NOP;
   endfunction

endpackage

// File: rtl/commit_trace_monitor_if.sv
// Commit tap, trace drain and status bundle between the CPU side (master) and the
// monitor (slave). COMMIT_TRACE_BACKPRESSURE_EN adds the cpu_stall signal.
interface commit_trace_monitor_if
   import commit_trace_pkg::*;
#(
   parameter int DATA_W     = PKG_DATA_W,
   parameter int REG_ADDR_W = PKG_REG_ADDR_W,
   parameter int CNT_W      = PKG_CNT_W
) ();

   logic                  commit_valid;
   logic [DATA_W-1:0]     pc;
   logic [DATA_W-1:0]     inst;
   logic                  reg_write;
   logic [REG_ADDR_W-1:0] write_reg;
   logic [DATA_W-1:0]     write_data;
   logic                  mem_read;
   logic                  mem_write;
   logic [DATA_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_data;
   logic                  halt;

   logic                  trace_valid;
   logic                  trace_ready;
   trace_kind_e           trace_kind;
   logic [CNT_W-1:0]      trace_inst_num;
   logic [DATA_W-1:0]     trace_pc;
   logic [REG_ADDR_W-1:0] trace_reg;
   logic [DATA_W-1:0]     trace_value;
   logic [DATA_W-1:0]     trace_addr;

   logic [CNT_W-1:0]      inst_count;
   logic [CNT_W-1:0]      cycle_count;
   logic                  halted;
   logic                  timeout;
   logic                  overflow;

`ifdef COMMIT_TRACE_BACKPRESSURE_EN
   logic                  cpu_stall;

   modport master (
      output commit_valid, pc, inst, reg_write, write_reg, write_data,
             mem_read, mem_write, mem_addr, mem_data, halt, trace_ready,
      input  trace_valid, trace_kind, trace_inst_num, trace_pc, trace_reg,
             trace_value, trace_addr, inst_count, cycle_count, halted,
             timeout, overflow, cpu_stall
   );

   modport slave (
      input  commit_valid, pc, inst, reg_write, write_reg, write_data,
             mem_read, mem_write, mem_addr, mem_data, halt, trace_ready,
      output trace_valid, trace_kind, trace_inst_num, trace_pc, trace_reg,
             trace_value, trace_addr, inst_count, cycle_count, halted,
             timeout, overflow, cpu_stall
   );
`else
   modport master (
      output commit_valid, pc, inst, reg_write, write_reg, write_data,
             mem_read, mem_write, mem_addr, mem_data, halt, trace_ready,
      input  trace_valid, trace_kind, trace_inst_num, trace_pc, trace_reg,
             trace_value, trace_addr, inst_count, cycle_count, halted,
             timeout, overflow
   );

   modport slave (
      input  commit_valid, pc, inst, reg_write, write_reg, write_data,
             mem_read, mem_write, mem_addr, mem_data, halt, trace_ready,
      output trace_valid, trace_kind, trace_inst_num, trace_pc, trace_reg,
             trace_value, trace_addr, inst_count, cycle_count, halted,
             timeout, overflow
   );
`endif

endinterface

// File: rtl/commit_trace_monitor_trace_fifo.sv
// trace_fifo: synchronous FIFO with combinational head. A push while full only
// lands when a pop frees the slot in the same cycle.
module trace_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_pop_ok  = i_pop && !o_empty;
   assign w_push_ok = i_push && (!o_full || w_pop_ok);

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
      end
   end

   // NOTE: storage has no reset; stale entries are unreachable because the pointers
   // and occupancy are reset, and the consumer zeroes the head while empty.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/commit_trace_monitor.sv
// commit_trace_monitor: classifies, numbers and queues committed instructions, with
// cycle/instruction counters, watchdog and overflow flag. Optional: COMMIT_TRACE_BACKPRESSURE_EN.
module commit_trace_monitor
   import commit_trace_pkg::*;
#(
   parameter int DATA_W         = PKG_DATA_W,
   parameter int REG_ADDR_W     = PKG_REG_ADDR_W,
   parameter int CNT_W          = PKG_CNT_W,
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input logic              clk,
   input logic              rst_n,
   commit_trace_monitor_if.slave bus
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [CNT_W-1:0] r_inst_count;
   logic [CNT_W-1:0] r_cycle_count;
   logic             r_halted;
   logic             r_timeout;
   logic             r_overflow;

   logic             w_accept;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic [CW-1:0]    w_count;
   trace_kind_e      w_kind;
   trace_rec_t       w_rec;
   trace_rec_t       w_head;
   trace_rec_t       w_out;

   assign w_accept = bus.commit_valid && !r_halted && !r_timeout;
   assign w_pop    = bus.trace_ready && !w_empty;
   assign w_kind   = classify_commit(bus.reg_write, bus.mem_read, bus.mem_write, bus.halt);

   // NOTE: every field gets a default before the case so no latch is inferred.
   always_comb begin
      w_rec          = '0;
      w_rec.kind     = w_kind;
      w_rec.inst_num = r_inst_count;
      w_rec.pc       = bus.pc;
      case (w_kind)
         KIND_LD: begin
            w_rec.reg_idx = bus.write_reg;
            w_rec.value   = bus.write_data;
            w_rec.addr    = bus.mem_addr;
         end
         KIND_REG: begin
            w_rec.reg_idx = bus.write_reg;
            w_rec.value   = bus.write_data;
         end
         KIND_ST: begin
            w_rec.value = bus.mem_data;
            w_rec.addr  = bus.mem_addr;
         end
         default: ;
      endcase
   end

   trace_fifo #(
      .WIDTH ($bits(trace_rec_t)),
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_accept),
      .i_data  (w_rec),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // Record outputs read as zero whenever nothing is queued.
   assign w_out = (w_count == '0) ? '0 : w_head;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inst_count  <= '0;
         r_cycle_count <= '0;
         r_halted      <= 1'b0;
         r_timeout     <= 1'b0;
      end else begin
         if (!r_halted && !r_timeout) begin
            if (r_cycle_count != '1) r_cycle_count <= r_cycle_count + 1'b1;
            if (r_cycle_count == CNT_W'(TIMEOUT_CYCLES - 1)) r_timeout <= 1'b1;
         end
         if (w_accept) begin
            r_inst_count <= r_inst_count + 1'b1;
            if (w_kind == KIND_HALT) r_halted <= 1'b1;
         end
      end
   end

`ifdef COMMIT_TRACE_BACKPRESSURE_EN
   logic          r_cpu_stall;
   logic [CW-1:0] w_count_next;

   assign w_count_next = w_count + CW'(w_accept && (!w_full || w_pop)) - CW'(w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cpu_stall <= 1'b0;
      end else begin
         r_cpu_stall <= (CW'(FIFO_DEPTH) - w_count_next) <= CW'(1);
      end
   end

   // The CPU is expected to honour cpu_stall; a commit into a full FIFO is a bug upstream.
   always_ff @(posedge clk) begin
      if (rst_n) assert (!(w_accept && w_full && !w_pop));
   end

   assign r_overflow    = 1'b0;
   assign bus.cpu_stall = r_cpu_stall;
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow <= 1'b0;
      end else if (w_accept && w_full && !w_pop) begin
         r_overflow <= 1'b1;
      end
   end
`endif

   assign bus.trace_valid    = !w_empty;
   assign bus.trace_kind     = w_out.kind;
   assign bus.trace_inst_num = w_out.inst_num;
   assign bus.trace_pc       = w_out.pc;
   assign bus.trace_reg      = w_out.reg_idx;
   assign bus.trace_value    = w_out.value;
   assign bus.trace_addr     = w_out.addr;
   assign bus.inst_count     = r_inst_count;
   assign bus.cycle_count    = r_cycle_count;
   assign bus.halted         = r_halted;
   assign bus.timeout        = r_timeout;
   assign bus.overflow       = r_overflow;

endmodule
